// File: rtl/mult_booth_param.sv
// Sequential radix-2 Booth multiplier with a start/busy/done handshake, signed or unsigned.
// Optional MULT_ZERO_SKIP_EN: a zero operand finishes in one cycle.
module mult_booth_param #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             is_signed,
  input  logic             start_operation,
  output logic             busy,
  output logic             stop_operation,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [WIDTH:0]  m_q, m_d;
  logic [WIDTH:0]  a_q, a_d;
  logic [WIDTH:0]  q_q, q_d;
  logic            qm1_q, qm1_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic            stop_q, stop_d;

  logic [WIDTH:0]  a_sum;
  logic            zero_skip;

`ifdef MULT_ZERO_SKIP_EN
  assign zero_skip = (in_A == '0) || (in_B == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // Booth recoding of the pair {Q[0], Q-1}; wraps modulo 2^(WIDTH+1).
  always_comb begin
    a_sum = a_q;
    unique case ({q_q[0], qm1_q})
      2'b10:   a_sum = a_q - m_q;
      2'b01:   a_sum = a_q + m_q;
      default: a_sum = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stop_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_operation) begin
          m_d   = {is_signed & in_B[WIDTH-1], in_B};
          q_d   = {is_signed & in_A[WIDTH-1], in_A};
          a_d   = '0;
          qm1_d = 1'b0;
          cnt_d = '0;
          if (zero_skip) begin
            q_d     = '0;
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        a_d   = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_d   = {a_sum[0], q_q[WIDTH:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Product {A, Q} truncated to 2*WIDTH bits.
        hi_d    = {a_q[WIDTH-2:0], q_q[WIDTH]};
        lo_d    = q_q[WIDTH-1:0];
        stop_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      stop_q  <= stop_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign stop_operation = stop_q;
  assign HI             = hi_q;
  assign LO             = lo_q;

endmodule

// File: tb/tb_mult_booth_param.sv
// Directed, table-driven bench for mult_booth_param at WIDTH=32 and WIDTH=8.
module tb_mult_booth_param;

  logic clk;
  logic reset;

  logic [31:0] in_a32, in_b32, hi32, lo32;
  logic        sgn32, start32, busy32, stop32;
  logic [7:0]  in_a8, in_b8, hi8, lo8;
  logic        sgn8, start8, busy8, stop8;

  int n_cmp;
  int n_fail;

  mult_booth_param #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_A(in_a32), .in_B(in_b32), .is_signed(sgn32),
    .start_operation(start32), .busy(busy32), .stop_operation(stop32), .HI(hi32), .LO(lo32)
  );

  mult_booth_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_A(in_a8), .in_B(in_b8), .is_signed(sgn8),
    .start_operation(start8), .busy(busy8), .stop_operation(stop8), .HI(hi8), .LO(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec32_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sgn;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec8_t;

  vec32_t v32[12];
  vec8_t  v8[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat32(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_SKIP_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return 34;
  endfunction

  // Starts one op; intf>0 pulses a new start with other operands in that cycle of RUN.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input int intf, output int lat, output logic busy0,
                       output logic [31:0] hi0, output logic [31:0] lo0);
    @(negedge clk);
    in_a32 = a; in_b32 = b; sgn32 = sgn; start32 = 1'b1;
    @(posedge clk); #1;
    busy0 = busy32; hi0 = hi32; lo0 = lo32;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == intf) begin
        start32 = 1'b1; in_a32 = 32'd5; in_b32 = 32'd5; sgn32 = 1'b0;
      end else begin
        start32 = 1'b0;
      end
      @(posedge clk); #1;
      if (stop32) begin
        lat = i;
        break;
      end
    end
    start32 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                      output int lat);
    @(negedge clk);
    in_a8 = a; in_b8 = b; sgn8 = sgn; start8 = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      @(posedge clk); #1;
      if (stop8) begin
        lat = i;
        break;
      end
    end
    start8 = 1'b0;
  endtask

  initial begin
    int          lat;
    int          pulses;
    logic        b0;
    logic [31:0] h0, l0;

    n_cmp = 0; n_fail = 0;
    reset = 1'b0;
    start32 = 1'b0; in_a32 = '0; in_b32 = '0; sgn32 = 1'b0;
    start8 = 1'b0; in_a8 = '0; in_b8 = '0; sgn8 = 1'b0;

    v32[0]  = '{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    v32[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    v32[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
    v32[3]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
    v32[4]  = '{32'h8000_0000, 32'h0000_0003, 1'b0, 32'h0000_0001, 32'h8000_0000};
    v32[5]  = '{32'h8000_0000, 32'h0000_0003, 1'b1, 32'hFFFF_FFFE, 32'h8000_0000};
    v32[6]  = '{32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001, 32'h0000_0000};
    v32[7]  = '{32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    v32[8]  = '{32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 32'h0000_0004, 32'hFFFF_FFFB};
    v32[9]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h3FFF_FFFF, 32'h0000_0001};
    v32[10] = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'h0000_0000, 32'h8000_0000};
    v32[11] = '{32'h1234_5678, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000};

    v8[0] = '{8'h80, 8'hFF, 1'b1, 8'h00, 8'h80};
    v8[1] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 8'h80};
    v8[2] = '{8'h7F, 8'h7F, 1'b1, 8'h3F, 8'h01};
    v8[3] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 8'h01};

    #1;
    chk("rst_busy", 64'(busy32), 64'd0);
    chk("rst_stop", 64'(stop32), 64'd0);
    chk("rst_hi", 64'(hi32), 64'd0);
    chk("rst_lo", 64'(lo32), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run32(v32[i].a, v32[i].b, v32[i].sgn, 0, lat, b0, h0, l0);
      chk($sformatf("v%0d_busy_e0", i), 64'(b0), 64'd1);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(exp_lat32(v32[i].a, v32[i].b)));
      chk($sformatf("v%0d_hi", i), 64'(hi32), 64'(v32[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(lo32), 64'(v32[i].lo));
      chk($sformatf("v%0d_busy_done", i), 64'(busy32), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_stop_drop", i), 64'(stop32), 64'd0);
    end

    for (int i = 0; i < 4; i++) begin
      run8(v8[i].a, v8[i].b, v8[i].sgn, lat);
      chk($sformatf("w8_%0d_lat", i), 64'(lat), 64'd10);
      chk($sformatf("w8_%0d_hi", i), 64'(hi8), 64'(v8[i].hi));
      chk($sformatf("w8_%0d_lo", i), 64'(lo8), 64'(v8[i].lo));
      chk($sformatf("w8_%0d_busy", i), 64'(busy8), 64'd0);
    end

    // Start during RUN is ignored; start in the done cycle is accepted back-to-back.
    run32(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 5, lat, b0, h0, l0);
    chk("ign_lat", 64'(lat), 64'd34);
    chk("ign_hi", 64'(hi32), 64'hFFFF_FFFF);
    chk("ign_lo", 64'(lo32), 64'hFFFF_FFEB);
    run32(32'h0000_0006, 32'h0000_0007, 1'b0, 0, lat, b0, h0, l0);
    chk("b2b_busy_e0", 64'(b0), 64'd1);
    chk("b2b_hi_held", 64'(h0), 64'hFFFF_FFFF);
    chk("b2b_lo_held", 64'(l0), 64'hFFFF_FFEB);
    chk("b2b_lat", 64'(lat), 64'd34);
    chk("b2b_hi", 64'(hi32), 64'h0000_0000);
    chk("b2b_lo", 64'(lo32), 64'h0000_002A);

    // Zero operand after a nonzero result.
    run32(32'h0000_0009, 32'h0000_0000, 1'b0, 0, lat, b0, h0, l0);
    chk("zero_lat", 64'(lat), 64'(exp_lat32(32'h9, 32'h0)));
    chk("zero_hi", 64'(hi32), 64'd0);
    chk("zero_lo", 64'(lo32), 64'd0);

    // Reload a nonzero result, then reset 10 cycles into the next operation.
    run32(32'h0000_0003, 32'h0000_0005, 1'b0, 0, lat, b0, h0, l0);
    chk("pre_rst_lo", 64'(lo32), 64'd15);
    @(negedge clk);
    in_a32 = 32'h0000_0011; in_b32 = 32'h0000_0013; sgn32 = 1'b0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 64'(busy32), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy32), 64'd0);
    chk("mid_rst_stop", 64'(stop32), 64'd0);
    chk("mid_rst_hi", 64'(hi32), 64'd0);
    chk("mid_rst_lo", 64'(lo32), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (stop32 || busy32) pulses++;
    end
    chk("no_done_after_rst", 64'(pulses), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
